// File: rtl/wb_queue_pkg.sv
// Shared definitions for the writeback queue: register-index type and the PC register index.
package wb_queue_pkg;

    typedef logic [3:0] reg_addr_t;

    localparam reg_addr_t PC_REG = 4'b1111;

    function automatic logic is_pc(input reg_addr_t addr);
        return addr == PC_REG;
    endfunction

endpackage

// File: rtl/wb_queue_fwd_search.sv
// Combinational youngest-match search over the queued entries, oldest to youngest.
module wb_fwd_search
    import wb_queue_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int DEPTH   = 4
) (
    input  reg_addr_t                  addr_q [DEPTH],
    input  logic [D_WIDTH-1:0]         data_q [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   head,
    input  logic [$clog2(DEPTH):0]     count,
    input  reg_addr_t                  fwd_addr,
    output logic                       fwd_hit,
    output logic [D_WIDTH-1:0]         fwd_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] idx;

    // Walking from head towards tail, a later match overrides an earlier one.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count && addr_q[idx] == fwd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// In-order writeback queue: up to two pushes and two register-file writes per cycle,
// r15 results redirected to the PC write port, plus a read-bypass lookup.
module wb_queue
    import wb_queue_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_v0,
    input  logic [3:0]         i_a0,
    input  logic [D_WIDTH-1:0] i_d0,
    input  logic               i_v1,
    input  logic [3:0]         i_a1,
    input  logic [D_WIDTH-1:0] i_d1,
    output logic               o_in_ready,
    output logic               o_WE1,
    output logic [3:0]         o_WA1,
    output logic [D_WIDTH-1:0] o_WD1,
    output logic               o_WE2,
    output logic [3:0]         o_WA2,
    output logic [D_WIDTH-1:0] o_WD2,
    output logic               o_pc_we,
    output logic [D_WIDTH-1:0] o_pc_wd,
    input  logic [3:0]         i_fwd_addr,
    output logic               o_fwd_hit,
    output logic [D_WIDTH-1:0] o_fwd_data,
    output logic               o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    reg_addr_t          addr_q [DEPTH];
    logic [D_WIDTH-1:0] data_q [DEPTH];
    logic [PW-1:0]      head, tail, head1, tail1;
    logic [CW-1:0]      count;
    logic               push0, push1;
    logic [1:0]         n_push, n_pop;

    assign o_in_ready = count <= CW'(DEPTH - 2);
    assign o_empty    = count == '0;
    assign push0      = o_in_ready & i_v0;
    assign push1      = o_in_ready & i_v1;
    assign n_push     = {1'b0, push0} + {1'b0, push1};
    assign head1      = head + PW'(1);
    assign tail1      = tail + PW'(1);

    // The second entry is held back when it shares an address with the first, since the
    // register file would silently drop port 2; rst suppresses writes in the reset cycle.
    always_comb begin
        o_WE1   = 1'b0;
        o_WA1   = '0;
        o_WD1   = '0;
        o_WE2   = 1'b0;
        o_WA2   = '0;
        o_WD2   = '0;
        o_pc_we = 1'b0;
        o_pc_wd = '0;
        if (!rst && count != '0) begin
            if (is_pc(addr_q[head])) begin
                o_pc_we = 1'b1;
                o_pc_wd = data_q[head];
            end else begin
                o_WE1 = 1'b1;
                o_WA1 = addr_q[head];
                o_WD1 = data_q[head];
                if (count >= CW'(2) && !is_pc(addr_q[head1]) &&
                    addr_q[head1] != addr_q[head]) begin
                    o_WE2 = 1'b1;
                    o_WA2 = addr_q[head1];
                    o_WD2 = data_q[head1];
                end
            end
        end
    end

    assign n_pop = {1'b0, o_WE1 | o_pc_we} + {1'b0, o_WE2};

    always_ff @(posedge clk) begin
        if (push0) begin
            addr_q[tail] <= i_a0;
            data_q[tail] <= i_d0;
        end
        if (push1) begin
            addr_q[push0 ? tail1 : tail] <= i_a1;
            data_q[push0 ? tail1 : tail] <= i_d1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(n_pop);
            tail  <= tail + PW'(n_push);
            count <= count + CW'(n_push) - CW'(n_pop);
        end
    end

    wb_fwd_search #(
        .D_WIDTH(D_WIDTH),
        .DEPTH  (DEPTH)
    ) u_fwd (
        .addr_q  (addr_q),
        .data_q  (data_q),
        .head    (head),
        .count   (count),
        .fwd_addr(i_fwd_addr),
        .fwd_hit (o_fwd_hit),
        .fwd_data(o_fwd_data)
    );

endmodule

// File: tb/tb_wb_queue.sv
// Directed self-checking bench for wb_queue with a shadow register file fed by the write ports.
module tb_wb_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_v0, i_v1;
    logic [3:0]  i_a0, i_a1, i_fwd_addr;
    logic [31:0] i_d0, i_d1;
    logic        o_in_ready, o_WE1, o_WE2, o_pc_we, o_fwd_hit, o_empty;
    logic [3:0]  o_WA1, o_WA2;
    logic [31:0] o_WD1, o_WD2, o_pc_wd, o_fwd_data;
    logic [31:0] rf [16];

    int checks = 0;
    int errors = 0;

    wb_queue #(.D_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .i_v0(i_v0), .i_a0(i_a0), .i_d0(i_d0),
        .i_v1(i_v1), .i_a1(i_a1), .i_d1(i_d1),
        .o_in_ready(o_in_ready),
        .o_WE1(o_WE1), .o_WA1(o_WA1), .o_WD1(o_WD1),
        .o_WE2(o_WE2), .o_WA2(o_WA2), .o_WD2(o_WD2),
        .o_pc_we(o_pc_we), .o_pc_wd(o_pc_wd),
        .i_fwd_addr(i_fwd_addr), .o_fwd_hit(o_fwd_hit), .o_fwd_data(o_fwd_data),
        .o_empty(o_empty)
    );

    always #5 clk = ~clk;

    // Register file: port 1 wins on an address collision.
    always @(posedge clk) begin
        if (o_WE2) rf[o_WA2] <= o_WD2;
        if (o_WE1) rf[o_WA1] <= o_WD1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [3:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [3:0] a1, input logic [31:0] d1);
        i_v0 = v0; i_a0 = a0; i_d0 = d0;
        i_v1 = v1; i_a1 = a1; i_d1 = d1;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); i_fwd_addr = 4'd0;
        step(); step();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks += 5;
            if (o_in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready cyc%0d: got %b expected 1", c, o_in_ready); end
            if (o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty cyc%0d: got %b expected 1", c, o_empty); end
            if (o_WE1 !== 1'b0) begin errors++; $display("FAIL reset_we1 cyc%0d: got %b expected 0", c, o_WE1); end
            if (o_WE2 !== 1'b0) begin errors++; $display("FAIL reset_we2 cyc%0d: got %b expected 0", c, o_WE2); end
            if (o_pc_we !== 1'b0) begin errors++; $display("FAIL reset_pcwe cyc%0d: got %b expected 0", c, o_pc_we); end
            step();
        end
    endtask

    task automatic test_dual_push();
        drive(1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22);
        step(); idle();
        checks += 6;
        if (o_WE1 !== 1'b1) begin errors++; $display("FAIL dual_we1: got %b expected 1", o_WE1); end
        if (o_WA1 !== 4'd1) begin errors++; $display("FAIL dual_wa1: got %0d expected 1", o_WA1); end
        if (o_WD1 !== 32'h11) begin errors++; $display("FAIL dual_wd1: got %0h expected 11", o_WD1); end
        if (o_WE2 !== 1'b1) begin errors++; $display("FAIL dual_we2: got %b expected 1", o_WE2); end
        if (o_WA2 !== 4'd2) begin errors++; $display("FAIL dual_wa2: got %0d expected 2", o_WA2); end
        if (o_WD2 !== 32'h22) begin errors++; $display("FAIL dual_wd2: got %0h expected 22", o_WD2); end
        step();
        checks += 1;
        if (o_empty !== 1'b1) begin errors++; $display("FAIL dual_empty: got %b expected 1", o_empty); end
    endtask

    task automatic test_same_addr();
        drive(1'b1, 4'd3, 32'hA, 1'b1, 4'd3, 32'hB);
        step(); idle();
        checks += 4;
        if (o_WE1 !== 1'b1) begin errors++; $display("FAIL same_c2_we1: got %b expected 1", o_WE1); end
        if (o_WA1 !== 4'd3) begin errors++; $display("FAIL same_c2_wa1: got %0d expected 3", o_WA1); end
        if (o_WD1 !== 32'hA) begin errors++; $display("FAIL same_c2_wd1: got %0h expected a", o_WD1); end
        if (o_WE2 !== 1'b0) begin errors++; $display("FAIL same_c2_we2: got %b expected 0", o_WE2); end
        step();
        checks += 4;
        if (o_WE1 !== 1'b1) begin errors++; $display("FAIL same_c3_we1: got %b expected 1", o_WE1); end
        if (o_WA1 !== 4'd3) begin errors++; $display("FAIL same_c3_wa1: got %0d expected 3", o_WA1); end
        if (o_WD1 !== 32'hB) begin errors++; $display("FAIL same_c3_wd1: got %0h expected b", o_WD1); end
        if (o_WE2 !== 1'b0) begin errors++; $display("FAIL same_c3_we2: got %b expected 0", o_WE2); end
        step();
        checks += 2;
        if (rf[3] !== 32'hB) begin errors++; $display("FAIL same_r3: got %0h expected b", rf[3]); end
        if (o_empty !== 1'b1) begin errors++; $display("FAIL same_empty: got %b expected 1", o_empty); end
    endtask

    task automatic test_pc();
        drive(1'b1, 4'd15, 32'h100, 1'b1, 4'd4, 32'h44);
        step(); idle();
        checks += 4;
        if (o_pc_we !== 1'b1) begin errors++; $display("FAIL pc_we: got %b expected 1", o_pc_we); end
        if (o_pc_wd !== 32'h100) begin errors++; $display("FAIL pc_wd: got %0h expected 100", o_pc_wd); end
        if (o_WE1 !== 1'b0) begin errors++; $display("FAIL pc_we1: got %b expected 0", o_WE1); end
        if (o_WE2 !== 1'b0) begin errors++; $display("FAIL pc_we2: got %b expected 0", o_WE2); end
        step();
        checks += 4;
        if (o_WE1 !== 1'b1) begin errors++; $display("FAIL pc_next_we1: got %b expected 1", o_WE1); end
        if (o_WA1 !== 4'd4) begin errors++; $display("FAIL pc_next_wa1: got %0d expected 4", o_WA1); end
        if (o_WD1 !== 32'h44) begin errors++; $display("FAIL pc_next_wd1: got %0h expected 44", o_WD1); end
        if (o_pc_we !== 1'b0) begin errors++; $display("FAIL pc_next_pcwe: got %b expected 0", o_pc_we); end
        step();
    endtask

    task automatic test_single_slot1();
        drive(1'b0, 4'd9, 32'h99, 1'b1, 4'd8, 32'h88);
        step(); idle();
        checks += 4;
        if (o_WE1 !== 1'b1) begin errors++; $display("FAIL slot1_we1: got %b expected 1", o_WE1); end
        if (o_WA1 !== 4'd8) begin errors++; $display("FAIL slot1_wa1: got %0d expected 8", o_WA1); end
        if (o_WD1 !== 32'h88) begin errors++; $display("FAIL slot1_wd1: got %0h expected 88", o_WD1); end
        if (o_WE2 !== 1'b0) begin errors++; $display("FAIL slot1_we2: got %b expected 0", o_WE2); end
        step();
        checks += 1;
        if (o_empty !== 1'b1) begin errors++; $display("FAIL slot1_empty: got %b expected 1", o_empty); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 4'd1, 32'hA1, 1'b1, 4'd2, 32'hB2);
        step();
        drive(1'b1, 4'd3, 32'hC3, 1'b1, 4'd4, 32'hD4);
        checks += 2;
        if (o_WA1 !== 4'd1 || o_WD1 !== 32'hA1) begin errors++; $display("FAIL b2b_p1a: got %0d/%0h expected 1/a1", o_WA1, o_WD1); end
        if (o_WA2 !== 4'd2 || o_WD2 !== 32'hB2) begin errors++; $display("FAIL b2b_p2a: got %0d/%0h expected 2/b2", o_WA2, o_WD2); end
        step(); idle();
        checks += 3;
        if (o_WA1 !== 4'd3 || o_WD1 !== 32'hC3) begin errors++; $display("FAIL b2b_p1b: got %0d/%0h expected 3/c3", o_WA1, o_WD1); end
        if (o_WA2 !== 4'd4 || o_WD2 !== 32'hD4) begin errors++; $display("FAIL b2b_p2b: got %0d/%0h expected 4/d4", o_WA2, o_WD2); end
        if (o_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", o_in_ready); end
        step();
        checks += 1;
        if (o_empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b expected 1", o_empty); end
    endtask

    task automatic test_full_ready();
        drive(1'b1, 4'd5, 32'h1, 1'b1, 4'd5, 32'h2);
        step();
        checks += 3;
        if (o_in_ready !== 1'b1) begin errors++; $display("FAIL full_ready1: got %b expected 1", o_in_ready); end
        if (o_WD1 !== 32'h1) begin errors++; $display("FAIL full_wd1_1: got %0h expected 1", o_WD1); end
        if (o_WE2 !== 1'b0) begin errors++; $display("FAIL full_we2_1: got %b expected 0", o_WE2); end
        drive(1'b1, 4'd5, 32'h3, 1'b1, 4'd5, 32'h4);
        step();
        checks += 2;
        if (o_in_ready !== 1'b0) begin errors++; $display("FAIL full_ready2: got %b expected 0", o_in_ready); end
        if (o_WD1 !== 32'h2) begin errors++; $display("FAIL full_wd1_2: got %0h expected 2", o_WD1); end
        drive(1'b1, 4'd5, 32'hEE, 1'b1, 4'd5, 32'hFF);
        step(); idle();
        checks += 2;
        if (o_in_ready !== 1'b1) begin errors++; $display("FAIL full_ready3: got %b expected 1", o_in_ready); end
        if (o_WD1 !== 32'h3) begin errors++; $display("FAIL full_wd1_3: got %0h expected 3", o_WD1); end
        step();
        checks += 2;
        if (o_WD1 !== 32'h4) begin errors++; $display("FAIL full_wd1_4: got %0h expected 4", o_WD1); end
        if (o_WE1 !== 1'b1) begin errors++; $display("FAIL full_we1_4: got %b expected 1", o_WE1); end
        step();
        checks += 3;
        if (o_empty !== 1'b1) begin errors++; $display("FAIL full_empty: got %b expected 1", o_empty); end
        if (o_WE1 !== 1'b0) begin errors++; $display("FAIL full_dropped: got we1=%b wd1=%0h expected we1=0", o_WE1, o_WD1); end
        if (rf[5] !== 32'h4) begin errors++; $display("FAIL full_r5: got %0h expected 4", rf[5]); end
    endtask

    task automatic test_bypass();
        drive(1'b1, 4'd6, 32'h1, 1'b1, 4'd6, 32'h2);
        i_fwd_addr = 4'd6;
        #1;
        checks += 1;
        if (o_fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_incoming: got %b expected 0", o_fwd_hit); end
        step(); idle();
        checks += 2;
        if (o_fwd_hit !== 1'b1) begin errors++; $display("FAIL fwd_hit6: got %b expected 1", o_fwd_hit); end
        if (o_fwd_data !== 32'h2) begin errors++; $display("FAIL fwd_data6: got %0h expected 2", o_fwd_data); end
        i_fwd_addr = 4'd7;
        #1;
        checks += 2;
        if (o_fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_hit7: got %b expected 0", o_fwd_hit); end
        if (o_fwd_data !== 32'h0) begin errors++; $display("FAIL fwd_data7: got %0h expected 0", o_fwd_data); end
        i_fwd_addr = 4'd6;
        step();
        checks += 2;
        if (o_fwd_hit !== 1'b1) begin errors++; $display("FAIL fwd_hit_tail: got %b expected 1", o_fwd_hit); end
        if (o_fwd_data !== 32'h2) begin errors++; $display("FAIL fwd_data_tail: got %0h expected 2", o_fwd_data); end
        step();
        checks += 2;
        if (o_empty !== 1'b1) begin errors++; $display("FAIL fwd_empty: got %b expected 1", o_empty); end
        if (rf[6] !== 32'h2) begin errors++; $display("FAIL fwd_r6: got %0h expected 2", rf[6]); end
        drive(1'b1, 4'd6, 32'h33, 1'b1, 4'd6, 32'h44);
        step(); idle();
        rst = 1'b1;
        #1;
        checks += 1;
        if (o_WE1 !== 1'b0) begin errors++; $display("FAIL rst_cycle_we1: got %b expected 0", o_WE1); end
        step();
        rst = 1'b0;
        #1;
        checks += 4;
        if (o_fwd_hit !== 1'b0) begin errors++; $display("FAIL rst_fwd_hit: got %b expected 0", o_fwd_hit); end
        if (o_empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b expected 1", o_empty); end
        if (o_in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", o_in_ready); end
        if (rf[6] !== 32'h2) begin errors++; $display("FAIL rst_r6: got %0h expected 2", rf[6]); end
        step();
        checks += 1;
        if (o_WE1 !== 1'b0) begin errors++; $display("FAIL rst_after_we1: got %b expected 0", o_WE1); end
    endtask

    initial begin
        for (int r = 0; r < 16; r++) rf[r] = '0;
        test_reset();
        test_dual_push();
        test_same_addr();
        test_pc();
        test_single_slot1();
        test_back_to_back();
        test_full_ready();
        test_bypass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
